des_round_engine: RTL and testbench



---
 rtl/des_pkg.sv | 98 +++++++++
 rtl/des_f_function.sv | 21 ++
 rtl/des_round_engine.sv | 114 +++++++++++
 tb/tb_des_round_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, FSM encoding, and permutation helpers.
// Vectors use DES numbering: for x[N:1], DES bit i is x[N+1-i].
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each box is row-major: index = row*16 + col, row = {b1,b6}, col = b2..b5.
  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [64:1] des_ip(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[7'(65 - j)] = x[7'(65 - IP_T[6'(j - 1)])];
    return y;
  endfunction

  function automatic logic [64:1] des_fp(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[7'(65 - j)] = x[7'(65 - FP_T[6'(j - 1)])];
    return y;
  endfunction

  function automatic logic [48:1] des_e(input logic [32:1] x);
    logic [48:1] y;
    y = '0;
    for (int j = 1; j <= 48; j++) y[6'(49 - j)] = x[6'(33 - E_T[6'(j - 1)])];
    return y;
  endfunction

  function automatic logic [32:1] des_p(input logic [32:1] x);
    logic [32:1] y;
    y = '0;
    for (int j = 1; j <= 32; j++) y[6'(33 - j)] = x[6'(33 - P_T[5'(j - 1)])];
    return y;
  endfunction

  function automatic logic [3:0] des_sbox(input int n, input logic [5:0] b);
    return 4'(SBOX_T[3'(n)][{b[5], b[0], b[4:1]}]);
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R,K): expand, key mix, eight S-boxes, then P permutation.
module des_f_function
  import des_pkg::*;
(
  input  logic [32:1] r,
  input  logic [48:1] k,
  output logic [32:1] f
);

  logic [48:1] x;
  logic [32:1] s_out;

  assign x = des_e(r) ^ k;

  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign s_out[32-4*i -: 4] = des_sbox(i, x[48-6*i -: 6]);
  end

  assign f = des_p(s_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, valid/ready on both sides.
// Round keys come from the upstream scheduler and are not latched here.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [64:1] data_in,
  input  logic        decrypt,
  input  logic [48:1] key1,
  input  logic [48:1] key2,
  input  logic [48:1] key3,
  input  logic [48:1] key4,
  input  logic [48:1] key5,
  input  logic [48:1] key6,
  input  logic [48:1] key7,
  input  logic [48:1] key8,
  input  logic [48:1] key9,
  input  logic [48:1] key10,
  input  logic [48:1] key11,
  input  logic [48:1] key12,
  input  logic [48:1] key13,
  input  logic [48:1] key14,
  input  logic [48:1] key15,
  input  logic [48:1] key16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] data_out,
  output logic        busy
);

  state_t      state;
  logic [32:1] l_q, r_q;
  logic [4:0]  rnd;
  logic        dec_q;

  logic [48:1] keys [16];
  logic [4:0]  k_idx;
  logic [48:1] k_sel;
  logic [32:1] f_out;
  logic [32:1] r_new;
  logic        accept;

  assign keys = '{key1, key2, key3, key4, key5, key6, key7, key8,
                  key9, key10, key11, key12, key13, key14, key15, key16};

  // Decryption walks the same schedule backwards: round n uses key(17-n).
  always_comb begin
    k_idx = dec_q ? 5'(17 - int'(rnd)) : rnd;
    k_sel = '0;
    for (int i = 0; i < 16; i++)
      if (k_idx == 5'(i + 1)) k_sel = keys[4'(i)];
  end

  des_f_function u_f (
    .r (r_q),
    .k (k_sel),
    .f (f_out)
  );

  assign r_new    = l_q ^ f_out;
  assign in_ready = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      rnd       <= '0;
      dec_q     <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Also covers the DONE back-to-back case: old result is consumed on this edge.
      {l_q, r_q} <= des_ip(data_in);
      rnd        <= 5'd1;
      dec_q      <= decrypt;
      out_valid  <= 1'b0;
      busy       <= 1'b1;
      state      <= ROUND;
    end else begin
      case (state)
        ROUND: begin
          l_q <= r_q;
          r_q <= r_new;
          if (rnd == 5'(ROUNDS)) begin
            // Undo the last swap: output is FP(R16 || L16).
            data_out  <= des_fp({r_new, r_q});
            out_valid <= 1'b1;
            busy      <= 1'b0;
            rnd       <= '0;
            state     <= DONE;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: known-answer vectors plus random blocks
// checked against a bit-array DES model with its own key schedule.
module tb_des_round_engine;

  localparam int ROUNDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, decrypt, out_valid, out_ready, busy;
  logic [63:0] data_in, data_out;
  logic [47:0] sk [1:16];

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q [$];
  logic [63:0] cur_key;

  always #5 clk = ~clk;

  des_round_engine #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .decrypt(decrypt),
    .key1(sk[1]), .key2(sk[2]), .key3(sk[3]), .key4(sk[4]),
    .key5(sk[5]), .key6(sk[6]), .key7(sk[7]), .key8(sk[8]),
    .key9(sk[9]), .key10(sk[10]), .key11(sk[11]), .key12(sk[12]),
    .key13(sk[13]), .key14(sk[14]), .key15(sk[15]), .key16(sk[16]),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  // Reference tables, DES bit numbering (1-based entries)
  localparam int M_IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int M_FP [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int M_E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,
    14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int M_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int M_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,
    30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int M_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
    26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,
    46,42,50,36,29,32};
  localparam int M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int M_S [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  // Subkey r: PC1, rotate each half by the cumulative shift, then PC2.
  function automatic logic [47:0] subkey(input logic [63:0] key, input int r);
    bit cd [56];
    bit rot [56];
    logic [47:0] k;
    int tot = 0;
    for (int j = 0; j < 56; j++) cd[j] = key[64 - M_PC1[j]];
    for (int i = 0; i < r; i++) tot += M_SH[i];
    for (int j = 0; j < 28; j++) begin
      rot[j]      = cd[(j + tot) % 28];
      rot[28 + j] = cd[28 + (j + tot) % 28];
    end
    for (int j = 0; j < 48; j++) k[47 - j] = rot[M_PC2[j] - 1];
    return k;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                            input logic dec);
    bit m [64];
    bit lh [32];
    bit rh [32];
    bit e [48];
    bit s [32];
    bit nr [32];
    bit pre [64];
    logic [47:0] k;
    logic [63:0] res;
    int row, col, v;
    for (int j = 0; j < 64; j++) m[j] = blk[64 - M_IP[j]];
    for (int j = 0; j < 32; j++) begin lh[j] = m[j]; rh[j] = m[32 + j]; end
    for (int r = 1; r <= 16; r++) begin
      k = subkey(key, dec ? 17 - r : r);
      for (int j = 0; j < 48; j++) e[j] = rh[M_E[j] - 1] ^ k[47 - j];
      for (int b = 0; b < 8; b++) begin
        row = 2 * e[6*b] + e[6*b + 5];
        col = 8 * e[6*b + 1] + 4 * e[6*b + 2] + 2 * e[6*b + 3] + e[6*b + 4];
        v = M_S[b][row][col];
        for (int t = 0; t < 4; t++) s[4*b + t] = v[3 - t];
      end
      for (int j = 0; j < 32; j++) nr[j] = lh[j] ^ s[M_P[j] - 1];
      lh = rh;
      rh = nr;
    end
    for (int j = 0; j < 32; j++) begin pre[j] = rh[j]; pre[32 + j] = lh[j]; end
    for (int j = 0; j < 64; j++) res[63 - j] = pre[M_FP[j] - 1];
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_key(input logic [63:0] k);
    cur_key = k;
    for (int r = 1; r <= 16; r++) sk[r] = subkey(k, r);
  endtask

  task automatic issue(input logic [63:0] d, input logic dec, input logic [63:0] exp);
    int n = 0;
    in_valid = 1'b1; data_in = d; decrypt = dec;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end else exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = {$urandom, $urandom}; decrypt = 1'($urandom);
  endtask

  // Waits from an accept for out_valid; optionally checks the edge count.
  task automatic wait_out(input bit check_lat);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 40);
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    else if (check_lat) chk("latency", 64'(n), 64'(ROUNDS));
  endtask

  // Scoreboard monitor: a transfer completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", data_out, 64'hx);
      else chk("data_out", data_out, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] rk, rd;
    logic rdec;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; decrypt = 1'b0;
    set_key(64'h0);
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    rst = 1'b0; #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Known-answer vectors
    set_key(64'h133457799BBCDFF1);
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405); wait_out(1);
    issue(64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF); wait_out(1);
    set_key(64'h0E329232EA6D0D73);
    issue(64'h8787878787878787, 1'b0, 64'h0);                wait_out(1);
    issue(64'h0, 1'b1, 64'h8787878787878787);                wait_out(1);
    @(posedge clk); #1;

    // Busy protection: new blocks and decrypt toggles offered mid-block are ignored
    set_key(64'h133457799BBCDFF1);
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; data_in = {$urandom, $urandom}; decrypt = 1'($urandom);
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      chk("busy_flag", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(0);
    @(posedge clk); #1;

    // Backpressure: result held while the sink stalls
    out_ready = 1'b0;
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405); wait_out(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_data_out", data_out, 64'h85E813540F0AB405);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    chk("drain_busy", 64'(busy), 64'd0);

    // Back-to-back: consume first result and accept decrypt on the same edge
    out_ready = 1'b0;
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405); wait_out(1);
    out_ready = 1'b1;
    issue(64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF); wait_out(1);
    @(posedge clk); #1;

    // Asynchronous reset at round 8 aborts the block
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1; #1;
    exp_q.delete();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_data_out", data_out, 64'd0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("abort_no_output", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405); wait_out(1);

    // Random keys, blocks, directions and sink stalls against the model
    for (int i = 0; i < 10; i++) begin
      rk = {$urandom, $urandom}; rd = {$urandom, $urandom}; rdec = 1'($urandom);
      @(posedge clk); #1;
      set_key(rk);
      issue(rd, rdec, des_model(rk, rd, rdec));
      out_ready = 1'($urandom);
      wait_out(1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
